// File: rtl/iobus_responder.sv
// iobus_responder: memory-mapped I/O register window for a soft core.
// Switch/button inputs are synchronized, button rising edges and timer
// compare matches latch into a sticky STATUS register that drives a masked
// level interrupt. The compare timer is built only when IOBUS_TIMER_EN is
// defined; otherwise its offsets read 0 and STATUS[0] never sets.
module iobus_responder #(
  parameter logic [31:0] IO_BASE = 32'h1100_0000
) (
  input  logic        IO_CLOCK,
  input  logic        IO_RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  input  logic        IOBUS_RD,
  input  logic [15:0] SWITCHES,
  input  logic [3:0]  BUTTONS,
  output logic [31:0] IOBUS_IN,
  output logic [15:0] LEDS,
  output logic [15:0] SSEG_DATA,
  output logic        IO_INTR
);

  // Word indices within the 128-byte window
  localparam logic [4:0] W_SWITCHES = 5'h00;
  localparam logic [4:0] W_BUTTONS  = 5'h01;
  localparam logic [4:0] W_LEDS     = 5'h08;
  localparam logic [4:0] W_SSEG     = 5'h10;
  localparam logic [4:0] W_TCTRL    = 5'h18;
  localparam logic [4:0] W_TCOUNT   = 5'h19;
  localparam logic [4:0] W_TCMP     = 5'h1A;
  localparam logic [4:0] W_STATUS   = 5'h1B;
  localparam logic [4:0] W_IMASK    = 5'h1C;

  logic [31:0] offset;
  logic        in_win;
  logic [4:0]  widx;
  logic        wr_hit;
  logic        wr_leds, wr_sseg, wr_status, wr_imask;

  // Byte lanes are ignored: the address is word-aligned before the window test
  assign offset    = {IOBUS_ADDR[31:2], 2'b00} - IO_BASE;
  assign in_win    = (offset[31:7] == 25'd0);
  assign widx      = offset[6:2];
  assign wr_hit    = IOBUS_WR & in_win;
  assign wr_leds   = wr_hit & (widx == W_LEDS);
  assign wr_sseg   = wr_hit & (widx == W_SSEG);
  assign wr_status = wr_hit & (widx == W_STATUS);
  assign wr_imask  = wr_hit & (widx == W_IMASK);

  logic unused_bits;
  assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16], offset[1:0]};

  logic        tmr_set;
  logic [31:0] tctrl_rd, tcount_rd, tcmp_rd;

`ifdef IOBUS_TIMER_EN
  logic        wr_tctrl, wr_tcmp, tmr_match;
  logic [1:0]  tctrl_q, tctrl_d;
  logic [31:0] tcount_q, tcount_d, tcmp_q, tcmp_d;

  assign wr_tctrl  = wr_hit & (widx == W_TCTRL);
  assign wr_tcmp   = wr_hit & (widx == W_TCMP);
  assign tmr_match = tctrl_q[0] & (tcount_q == tcmp_q);
  assign tmr_set   = tmr_match;
  assign tctrl_rd  = {30'd0, tctrl_q};
  assign tcount_rd = tcount_q;
  assign tcmp_rd   = tcmp_q;

  // Timer next state: count, reload or stop on match; a TCTRL write wins
  always_comb begin
    tctrl_d  = tctrl_q;
    tcount_d = tcount_q;
    tcmp_d   = tcmp_q;
    if (tctrl_q[0]) begin
      if (tmr_match) begin
        if (tctrl_q[1]) tcount_d = 32'd0;
        else            tctrl_d[0] = 1'b0;
      end else begin
        tcount_d = tcount_q + 32'd1;
      end
    end
    if (wr_tctrl) begin
      tctrl_d = IOBUS_OUT[1:0];
      if (IOBUS_OUT[0] && !tctrl_q[0]) tcount_d = 32'd0;
    end
    if (wr_tcmp) tcmp_d = IOBUS_OUT;
  end

  // Timer registers; compare value resets to all-ones
  always_ff @(posedge IO_CLOCK or posedge IO_RESET) begin
    if (IO_RESET) begin
      tctrl_q  <= 2'd0;
      tcount_q <= 32'd0;
      tcmp_q   <= 32'hFFFF_FFFF;
    end else begin
      tctrl_q  <= tctrl_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
    end
  end
`else
  assign tmr_set   = 1'b0;
  assign tctrl_rd  = 32'd0;
  assign tcount_rd = 32'd0;
  assign tcmp_rd   = 32'd0;
`endif

  logic [15:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [3:0]  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_hist_q, btn_hist_d;
  logic [15:0] leds_q, leds_d, sseg_q, sseg_d;
  logic [4:0]  status_q, status_d, imask_q, imask_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic        intr_q, intr_d;
  logic [4:0]  status_clr;

  // Read mux over the current (pre-write) register contents
  always_comb begin
    rd_val = 32'd0;
    if (in_win) begin
      case (widx)
        W_SWITCHES: rd_val = {16'd0, sw_s2_q};
        W_BUTTONS:  rd_val = {28'd0, btn_s2_q};
        W_LEDS:     rd_val = {16'd0, leds_q};
        W_SSEG:     rd_val = {16'd0, sseg_q};
        W_TCTRL:    rd_val = tctrl_rd;
        W_TCOUNT:   rd_val = tcount_rd;
        W_TCMP:     rd_val = tcmp_rd;
        W_STATUS:   rd_val = {27'd0, status_q};
        W_IMASK:    rd_val = {27'd0, imask_q};
        default:    rd_val = 32'd0;
      endcase
    end
  end

  // Next state for synchronizers, writable registers, status and read data
  always_comb begin
    sw_s1_d    = SWITCHES;
    sw_s2_d    = sw_s1_q;
    btn_s1_d   = BUTTONS;
    btn_s2_d   = btn_s1_q;
    btn_hist_d = btn_s2_q;
    leds_d     = wr_leds  ? IOBUS_OUT[15:0] : leds_q;
    sseg_d     = wr_sseg  ? IOBUS_OUT[15:0] : sseg_q;
    imask_d    = wr_imask ? IOBUS_OUT[4:0]  : imask_q;
    status_clr = wr_status ? IOBUS_OUT[4:0] : 5'd0;
    // set events override a simultaneous write-one-to-clear
    status_d   = (status_q & ~status_clr) | {btn_s2_q & ~btn_hist_q, tmr_set};
    intr_d     = |(status_q & imask_q);
    rdata_d    = IOBUS_RD ? rd_val : rdata_q;
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge IO_CLOCK or posedge IO_RESET) begin
    if (IO_RESET) begin
      sw_s1_q    <= 16'd0;
      sw_s2_q    <= 16'd0;
      btn_s1_q   <= 4'd0;
      btn_s2_q   <= 4'd0;
      btn_hist_q <= 4'd0;
      leds_q     <= 16'd0;
      sseg_q     <= 16'd0;
      status_q   <= 5'd0;
      imask_q    <= 5'd0;
      rdata_q    <= 32'd0;
      intr_q     <= 1'b0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_hist_q <= btn_hist_d;
      leds_q     <= leds_d;
      sseg_q     <= sseg_d;
      status_q   <= status_d;
      imask_q    <= imask_d;
      rdata_q    <= rdata_d;
      intr_q     <= intr_d;
    end
  end

  assign IOBUS_IN  = rdata_q;
  assign LEDS      = leds_q;
  assign SSEG_DATA = sseg_q;
  assign IO_INTR   = intr_q;

endmodule

// File: tb/tb_iobus_responder.sv
// Testbench for iobus_responder: vector table, directed multi-cycle
// sequences, and randomized bus traffic against a register-map model.
// Timer expectations depend on IOBUS_TIMER_EN.
module tb_iobus_responder;

  localparam logic [31:0] BASE = 32'h1100_0000;
`ifdef IOBUS_TIMER_EN
  localparam logic [31:0] EXP_TCMP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_TCMP = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        IO_RESET;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT;
  logic        IOBUS_WR, IOBUS_RD;
  logic [15:0] SWITCHES;
  logic [3:0]  BUTTONS;
  logic [31:0] IOBUS_IN;
  logic [15:0] LEDS, SSEG_DATA;
  logic        IO_INTR;

  int checks = 0;
  int errors = 0;

  iobus_responder #(.IO_BASE(BASE)) dut (
    .IO_CLOCK(clk), .IO_RESET(IO_RESET),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_RD(IOBUS_RD),
    .SWITCHES(SWITCHES), .BUTTONS(BUTTONS),
    .IOBUS_IN(IOBUS_IN), .LEDS(LEDS), .SSEG_DATA(SSEG_DATA), .IO_INTR(IO_INTR)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (register map view) ----------------
  logic [15:0] m_leds, m_sseg;
  logic [4:0]  m_status, m_imask;
  logic        m_intr;
  logic [31:0] m_rdata;
  logic [15:0] sw_hist [2];   // [0]=sampled last edge, [1]=two edges ago
  logic [3:0]  bt_hist [3];
`ifdef IOBUS_TIMER_EN
  logic        m_ten, m_tauto;
  logic [31:0] m_tcnt, m_tcmp;
`endif

  task automatic m_reset();
    m_leds = 0; m_sseg = 0; m_status = 0; m_imask = 0; m_intr = 0; m_rdata = 0;
    sw_hist[0] = 0; sw_hist[1] = 0;
    bt_hist[0] = 0; bt_hist[1] = 0; bt_hist[2] = 0;
`ifdef IOBUS_TIMER_EN
    m_ten = 0; m_tauto = 0; m_tcnt = 0; m_tcmp = 32'hFFFF_FFFF;
`endif
  endtask

  // One clock edge worth of register-map behaviour, using the inputs now applied
  task automatic m_step();
    logic [31:0] off, rv;
    logic        inwin, wr;
    logic [4:0]  setb, clrb;
    off   = {IOBUS_ADDR[31:2], 2'b00} - BASE;
    inwin = off < 32'h80;
    wr    = IOBUS_WR && inwin;
    rv    = 0;
    if (inwin) begin
      case (off)
        32'h00: rv = {16'h0, sw_hist[1]};
        32'h04: rv = {28'h0, bt_hist[1]};
        32'h20: rv = {16'h0, m_leds};
        32'h40: rv = {16'h0, m_sseg};
`ifdef IOBUS_TIMER_EN
        32'h60: rv = {30'h0, m_tauto, m_ten};
        32'h64: rv = m_tcnt;
        32'h68: rv = m_tcmp;
`endif
        32'h6C: rv = {27'h0, m_status};
        32'h70: rv = {27'h0, m_imask};
        default: rv = 0;
      endcase
    end
    m_intr = |(m_status & m_imask);
    setb   = {bt_hist[1] & ~bt_hist[2], 1'b0};
`ifdef IOBUS_TIMER_EN
    begin
      logic was_en;
      was_en = m_ten;
      if (m_ten && m_tcnt == m_tcmp) begin
        setb[0] = 1'b1;
        if (m_tauto) m_tcnt = 0;
        else         m_ten  = 0;
      end else if (m_ten) begin
        m_tcnt = m_tcnt + 1;
      end
      if (wr && off == 32'h60) begin
        if (IOBUS_OUT[0] && !was_en) m_tcnt = 0;
        m_ten   = IOBUS_OUT[0];
        m_tauto = IOBUS_OUT[1];
      end
      if (wr && off == 32'h68) m_tcmp = IOBUS_OUT;
    end
`endif
    clrb = (wr && off == 32'h6C) ? IOBUS_OUT[4:0] : 5'h0;
    m_status = (m_status & ~clrb) | setb;
    if (wr && off == 32'h20) m_leds  = IOBUS_OUT[15:0];
    if (wr && off == 32'h40) m_sseg  = IOBUS_OUT[15:0];
    if (wr && off == 32'h70) m_imask = IOBUS_OUT[4:0];
    if (IOBUS_RD) m_rdata = rv;
    bt_hist[2] = bt_hist[1]; bt_hist[1] = bt_hist[0]; bt_hist[0] = BUTTONS;
    sw_hist[1] = sw_hist[0]; sw_hist[0] = SWITCHES;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk); #1;
    chk("model_iobus_in", IOBUS_IN, m_rdata);
    chk("model_leds", {16'h0, LEDS}, {16'h0, m_leds});
    chk("model_sseg", {16'h0, SSEG_DATA}, {16'h0, m_sseg});
    chk("model_intr", {31'h0, IO_INTR}, {31'h0, m_intr});
  endtask

  task automatic bus(input logic [31:0] off, input logic [31:0] wd, input logic wr, input logic rd);
    IOBUS_ADDR = BASE + off; IOBUS_OUT = wd; IOBUS_WR = wr; IOBUS_RD = rd;
    tick();
    IOBUS_WR = 1'b0; IOBUS_RD = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] off;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [31:0] exp_in;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t        vecs [18];
  logic [31:0] offs [13];

  initial begin
    vecs[0]  = '{32'h20,       32'h0000_A5A5, 1'b1, 1'b0, 32'h0,        16'hA5A5};
    vecs[1]  = '{32'h20,       32'h0,         1'b0, 1'b1, 32'h0000_A5A5, 16'hA5A5};
    vecs[2]  = '{32'h40,       32'h1234_BEEF, 1'b1, 1'b0, 32'h0000_A5A5, 16'hA5A5};
    vecs[3]  = '{32'h40,       32'h0,         1'b0, 1'b1, 32'h0000_BEEF, 16'hA5A5};
    vecs[4]  = '{32'h20,       32'h0000_5A5A, 1'b1, 1'b1, 32'h0000_A5A5, 16'h5A5A};
    vecs[5]  = '{32'h23,       32'h0,         1'b0, 1'b1, 32'h0000_5A5A, 16'h5A5A};
    vecs[6]  = '{32'h70,       32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_5A5A, 16'h5A5A};
    vecs[7]  = '{32'h70,       32'h0,         1'b0, 1'b1, 32'h0000_001F, 16'h5A5A};
    vecs[8]  = '{32'h7C,       32'h0,         1'b0, 1'b1, 32'h0,        16'h5A5A};
    vecs[9]  = '{32'hA0,       32'h0000_1111, 1'b1, 1'b0, 32'h0,        16'h5A5A};
    vecs[10] = '{32'hA0,       32'h0,         1'b0, 1'b1, 32'h0,        16'h5A5A};
    vecs[11] = '{32'hFFFF_FFA0, 32'h0000_FFFF, 1'b1, 1'b1, 32'h0,       16'h5A5A};
    vecs[12] = '{32'h00,       32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,        16'h5A5A};
    vecs[13] = '{32'h00,       32'h0,         1'b0, 1'b1, 32'h0000_0F0F, 16'h5A5A};
    vecs[14] = '{32'h04,       32'h0,         1'b0, 1'b1, 32'h0,        16'h5A5A};
    vecs[15] = '{32'h68,       32'h0,         1'b0, 1'b1, EXP_TCMP,     16'h5A5A};
    vecs[16] = '{32'h6C,       32'h0,         1'b0, 1'b1, 32'h0,        16'h5A5A};
    vecs[17] = '{32'h20,       32'h0,         1'b1, 1'b0, 32'h0,        16'h0000};
    offs = '{32'h00, 32'h04, 32'h20, 32'h40, 32'h60, 32'h64, 32'h68,
             32'h6C, 32'h70, 32'h7C, 32'h10, 32'hA0, 32'hFFFF_FFA0};

    IO_RESET = 1'b1; IOBUS_ADDR = 0; IOBUS_OUT = 0; IOBUS_WR = 0; IOBUS_RD = 0;
    SWITCHES = 16'h0F0F; BUTTONS = 4'h0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_iobus_in", IOBUS_IN, 32'h0);
    chk("reset_leds", {16'h0, LEDS}, 32'h0);
    chk("reset_sseg", {16'h0, SSEG_DATA}, 32'h0);
    chk("reset_intr", {31'h0, IO_INTR}, 32'h0);
    IO_RESET = 1'b0;
    repeat (3) tick();

    // Vector table: register access, read timing, window and RO handling
    for (int i = 0; i < 18; i++) begin
      bus(vecs[i].off, vecs[i].wdata, vecs[i].wr, vecs[i].rd);
      chk($sformatf("vec%0d_iobus_in", i), IOBUS_IN, vecs[i].exp_in);
      chk($sformatf("vec%0d_leds", i), {16'h0, LEDS}, {16'h0, vecs[i].exp_leds});
    end

    // Button edge -> sticky STATUS[1] -> masked interrupt, then W1C
    bus(32'h70, 32'h2, 1'b1, 1'b0);
    BUTTONS = 4'h1;
    tick();
    tick();
    BUTTONS = 4'h0;
    tick();
    chk("btn_intr_before", {31'h0, IO_INTR}, 32'h0);
    bus(32'h6C, 32'h0, 1'b0, 1'b1);
    chk("btn_intr_set", {31'h0, IO_INTR}, 32'h1);
    chk("btn_status_read", IOBUS_IN, 32'h2);
    bus(32'h6C, 32'h2, 1'b1, 1'b0);
    chk("btn_intr_hold", {31'h0, IO_INTR}, 32'h1);
    tick();
    chk("btn_intr_clear", {31'h0, IO_INTR}, 32'h0);

`ifdef IOBUS_TIMER_EN
    // Auto-reload timer with TCMP=5; W1C colliding with a match at step 18
    bus(32'h6C, 32'h1F, 1'b1, 1'b0);
    bus(32'h70, 32'h1, 1'b1, 1'b0);
    bus(32'h68, 32'h5, 1'b1, 1'b0);
    bus(32'h60, 32'h3, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      logic [31:0] o;
      logic        w, r;
      o = 32'h6C; w = (i == 8 || i == 18); r = 1'b0;
      if (i == 10) begin o = 32'h64; r = 1'b1; end
      bus(o, 32'h1, w, r);
      chk($sformatf("tmr_intr_%0d", i), {31'h0, IO_INTR},
          {31'h0, ((i >= 7 && i <= 8) || i >= 13)});
      if (i == 10) chk("tmr_count", IOBUS_IN, 32'd3);
    end
    bus(32'h60, 32'h0, 1'b1, 1'b0);
`else
    // Timer absent: offsets read 0, STATUS[0] never sets
    bus(32'h68, 32'h0, 1'b1, 1'b0);
    bus(32'h60, 32'h3, 1'b1, 1'b0);
    repeat (4) tick();
    bus(32'h60, 32'h0, 1'b0, 1'b1);
    chk("notmr_tctrl", IOBUS_IN, 32'h0);
    bus(32'h64, 32'h0, 1'b0, 1'b1);
    chk("notmr_tcount", IOBUS_IN, 32'h0);
    bus(32'h6C, 32'h0, 1'b0, 1'b1);
    chk("notmr_status", IOBUS_IN, 32'h0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] off, wd;
      off = offs[$urandom_range(0, 12)] | 32'($urandom_range(0, 3));
      wd  = $urandom;
      if ((off & ~32'h3) == 32'h68) wd = 32'($urandom_range(0, 24));
      if ((off & ~32'h3) == 32'h60) wd = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) SWITCHES = 16'($urandom);
      if ($urandom_range(0, 5) == 0) BUTTONS = 4'($urandom);
      bus(off, wd, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end
    BUTTONS = 4'h0;

    // Asynchronous reset in mid-cycle with LEDS lit and timer counting
    bus(32'h20, 32'hFFFF, 1'b1, 1'b0);
    bus(32'h20, 32'h0, 1'b0, 1'b1);
    bus(32'h60, 32'h1, 1'b1, 1'b0);
    repeat (3) tick();
    #2;
    IO_RESET = 1'b1;
    #1;
    chk("arst_iobus_in", IOBUS_IN, 32'h0);
    chk("arst_leds", {16'h0, LEDS}, 32'h0);
    chk("arst_sseg", {16'h0, SSEG_DATA}, 32'h0);
    chk("arst_intr", {31'h0, IO_INTR}, 32'h0);
    m_reset();
    @(posedge clk); #1;
    IO_RESET = 1'b0;
    repeat (3) tick();
    bus(32'h68, 32'h0, 1'b0, 1'b1);
    chk("post_rst_tcmp", IOBUS_IN, EXP_TCMP);
    repeat (2) tick();
    bus(32'h64, 32'h0, 1'b0, 1'b1);
    chk("post_rst_tcount", IOBUS_IN, 32'h0);
    bus(32'h60, 32'h0, 1'b0, 1'b1);
    chk("post_rst_tctrl", IOBUS_IN, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iobus_responder.md
IOBUS_RESPONDER -- requirements
Module: iobus_responder

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h1100_0000, base address of the responder's register window.
REQ-002 SHALL have ports: IO_CLOCK  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have ports: IO_RESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: IOBUS_ADDR  in  32  byte address from memory stage; IOBUS_OUT  in  32  write data; IOBUS_WR  in  1  write strobe; IOBUS_RD  in  1  read request.
REQ-005 SHALL have ports: SWITCHES  in  16  board switches (async); BUTTONS  in  4  board buttons (async).
REQ-006 SHALL have ports: IOBUS_IN  out  32  read data; LEDS  out  16  LED register; SSEG_DATA  out  16  seven-segment value; IO_INTR  out  1  level interrupt to core.

Function
REQ-007 SHALL decode word offsets from IO_BASE: 0x00 SWITCHES (RO), 0x04 BUTTONS (RO), 0x20 LEDS (RW), 0x40 SSEG (RW), 0x60 TCTRL (RW), 0x64 TCOUNT (RO), 0x68 TCMP (RW), 0x6C STATUS (RW1C), 0x70 IMASK (RW); IOBUS_ADDR[1:0] ignored.
REQ-008 SHALL ignore writes to RO, unmapped, or out-of-window addresses; reads of those return 0 (RO registers still read their value).
REQ-009 SHALL register IOBUS_IN: value for address sampled on cycle N with IOBUS_RD=1 appears on cycle N+1 and holds until next read; IOBUS_RD=0 leaves IOBUS_IN unchanged.
REQ-010 SHALL, with IOBUS_RD and IOBUS_WR both high on one address, return the pre-write value and apply the write.
REQ-011 SHALL pass SWITCHES and BUTTONS through 2-flop synchronizers; register reads return synchronized values (2-cycle latency).
REQ-012 SHALL detect rising edges of synchronized BUTTONS[i] and set sticky STATUS[i+1].
REQ-013 SHALL implement 32-bit TCOUNT: increments by 1 per cycle while TCTRL[0] (enable)=1; writing TCTRL with bit0 rising 0->1 clears TCOUNT to 0.
REQ-014 SHALL, on cycle where enabled TCOUNT == TCMP, set sticky STATUS[0]; next cycle TCOUNT=0 if TCTRL[1] (auto-reload)=1, else TCOUNT holds and TCTRL[0] clears.
REQ-015 SHALL wrap TCOUNT 0xFFFF_FFFF -> 0 without setting STATUS[0] unless TCMP match.
REQ-016 SHALL clear STATUS bits written with 1; a set event in the same cycle as its clear wins (bit stays 1).
REQ-017 SHALL drive IO_INTR = |(STATUS[4:0] & IMASK[4:0]), registered (one cycle after STATUS/IMASK change).
REQ-018 SHALL drive LEDS = LEDS register[15:0], SSEG_DATA = SSEG register[15:0] directly; upper write bits discarded.

Reset
REQ-019 SHALL, on IO_RESET high, immediately clear IOBUS_IN, LEDS, SSEG_DATA, IO_INTR, TCTRL, TCOUNT, STATUS, IMASK, synchronizers, edge-detect history to 0 and set TCMP to 32'hFFFF_FFFF.
REQ-020 SHALL, on reset mid-count, abandon count; timer remains disabled after release until TCTRL written.

Configuration
REQ-021 SHALL compile timer logic only when IOBUS_TIMER_EN is defined.
REQ-022 SHALL, without IOBUS_TIMER_EN, read 0 at offsets 0x60/0x64/0x68, ignore writes there, hold STATUS[0] at 0; all other behaviour unchanged.

Verification
REQ-023 SHALL cover: write 0x0000_A5A5 to IO_BASE+0x20 -> LEDS=0xA5A5 next cycle; read same address -> IOBUS_IN=0x0000_A5A5 one cycle after IOBUS_RD.
REQ-024 SHALL cover: TCMP=5, TCTRL=0x3 -> STATUS[0] set on match, TCOUNT reloads to 0, STATUS[0] set again 6 cycles later.
REQ-025 SHALL cover: IMASK=0x2, pulse BUTTONS[0] -> STATUS[1]=1 after sync, IO_INTR=1 one cycle later; write 0x2 to STATUS -> IO_INTR=0.
REQ-026 SHALL cover: W1C of STATUS[0] in same cycle as timer match -> STATUS[0] remains 1.
REQ-027 SHALL cover: assert IO_RESET mid-count with LEDS=0xFFFF -> all outputs 0 asynchronously, TCMP reads 0xFFFF_FFFF after release.
REQ-028 SHALL cover: read unmapped IO_BASE+0x7C and write to IO_BASE+0x00 -> IOBUS_IN=0, SWITCHES read unchanged.
